// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- writeback stage of the pipeline.
//
// Holds the MEM/WB pipeline register and drives the decode stage's
// register-file write port. Each retired instruction produces exactly one
// write-enable pulse, including when the pipeline is frozen while the SRAM
// is not ready. It also keeps bring-up counters for retired instructions
// and for register writes.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   freeze          pipeline hold; the MEM/WB entry keeps its contents
//   mem_valid       MEM stage holds a real instruction (0 = bubble)
//   mem_wb_en       instruction writes a register
//   mem_r_en        instruction is a load (value comes from memory)
//   mem_alu_result  ALU result / effective address
//   mem_read_data   memory read data
//   mem_dest        destination register index
//   WB_WB_EN        register-file write enable (one cycle per instruction)
//   WB_WB_value     write data (load data or ALU result)
//   WB_WB_dest      write index, also used for forwarding
//   wb_valid        entry holds a valid instruction
//   retired_count   valid instructions retired (wraps)
//   write_count     register writes issued (wraps)
// ---------------------------------------------------------------------------
module wb_stage #(
   parameter int DATA_W       = 32,
   parameter int REG_ADDR_W   = 4,
   parameter int COUNT_W      = 16,
   parameter int SUPPRESS_R15 = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  freeze,
   input  logic                  mem_valid,
   input  logic                  mem_wb_en,
   input  logic                  mem_r_en,
   input  logic [DATA_W-1:0]     mem_alu_result,
   input  logic [DATA_W-1:0]     mem_read_data,
   input  logic [REG_ADDR_W-1:0] mem_dest,
   output logic                  WB_WB_EN,
   output logic [DATA_W-1:0]     WB_WB_value,
   output logic [REG_ADDR_W-1:0] WB_WB_dest,
   output logic                  wb_valid,
   output logic [COUNT_W-1:0]    retired_count,
   output logic [COUNT_W-1:0]    write_count
);

   // NEW is the single cycle in which an entry retires and writes; DONE marks
   // a frozen entry that has already been written and must not write again.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_NEW   = 2'd1,
      ST_DONE  = 2'd2
   } wb_state_e;

   wb_state_e               state_r;
   logic                    entry_wb_en_r;
   logic                    entry_r_en_r;
   logic [DATA_W-1:0]       entry_alu_r;
   logic [DATA_W-1:0]       entry_rdata_r;
   logic [REG_ADDR_W-1:0]   entry_dest_r;
   logic [COUNT_W-1:0]      retired_count_r;
   logic [COUNT_W-1:0]      write_count_r;
   logic                    dest_is_pc_s;
   logic                    wb_en_s;
   logic                    retire_s;

   // MEM/WB entry register and writeback FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= ST_EMPTY;
         entry_wb_en_r <= 1'b0;
         entry_r_en_r  <= 1'b0;
         entry_alu_r   <= {DATA_W{1'b0}};
         entry_rdata_r <= {DATA_W{1'b0}};
         entry_dest_r  <= {REG_ADDR_W{1'b0}};
      end else if (!freeze) begin
         // Write enable of a bubble is meaningless, so it is masked on load.
         entry_wb_en_r <= mem_valid & mem_wb_en;
         entry_r_en_r  <= mem_r_en;
         entry_alu_r   <= mem_alu_result;
         entry_rdata_r <= mem_read_data;
         entry_dest_r  <= mem_dest;
         state_r       <= mem_valid ? ST_NEW : ST_EMPTY;
      end else begin
         case (state_r)
            ST_EMPTY: state_r <= ST_EMPTY;
            ST_NEW:   state_r <= ST_DONE;
            ST_DONE:  state_r <= ST_DONE;
            default:  state_r <= ST_EMPTY;
         endcase
      end
   end

   // Write-enable decode; R15 writes can be dropped while still retiring.
   always_comb begin
      dest_is_pc_s = 1'b0;
      wb_en_s      = 1'b0;
      retire_s     = 1'b0;
      if ((SUPPRESS_R15 != 0) && (entry_dest_r == {REG_ADDR_W{1'b1}})) begin
         dest_is_pc_s = 1'b1;
      end else begin
         dest_is_pc_s = 1'b0;
      end
      if (state_r == ST_NEW) begin
         retire_s = 1'b1;
         wb_en_s  = entry_wb_en_r & ~dest_is_pc_s;
      end else begin
         retire_s = 1'b0;
         wb_en_s  = 1'b0;
      end
   end

   // Bring-up counters; both wrap silently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired_count_r <= {COUNT_W{1'b0}};
         write_count_r   <= {COUNT_W{1'b0}};
      end else if (retire_s) begin
         retired_count_r <= retired_count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
         write_count_r   <= write_count_r + {{(COUNT_W-1){1'b0}}, wb_en_s};
      end else begin
         retired_count_r <= retired_count_r;
         write_count_r   <= write_count_r;
      end
   end

   assign WB_WB_EN      = wb_en_s;
   assign WB_WB_value   = entry_r_en_r ? entry_rdata_r : entry_alu_r;
   assign WB_WB_dest    = entry_dest_r;
   assign wb_valid      = (state_r != ST_EMPTY);
   assign retired_count = retired_count_r;
   assign write_count   = write_count_r;

endmodule
